// File: rtl/ep_arb_nch.sv
// ep_arb_nch: N-channel endpoint arbiter for the shared TRN tx interface.
// Local requesters compete via req_ep/drv_ep/my_trn; the winner is forwarded
// upstream on chn_reqep/chn_drvn/chn_trn so arbiters can nest.
// Optional build macro EP_ARB_NCH_WDOG_EN: revokes a grant that is not
// driven within WDOG_CYCLES cycles and pulses wdog_evt.
module ep_arb_nch #(
  parameter int NUM_REQ     = 4,
  parameter int ARB_MODE    = 0,
  parameter int IDX_W       = 4,
  parameter int WDOG_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_ep,
  input  logic [NUM_REQ-1:0] drv_ep,
  output logic [NUM_REQ-1:0] my_trn,
  input  logic               chn_trn,
  output logic               chn_reqep,
  output logic               chn_drvn,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy,
  output logic               wdog_evt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_UP  = 3'd1,
    S_GRANT   = 3'd2,
    S_DRIVE   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);

  state_t               r_state, w_nxt;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_grant_idx;
  logic [NUM_REQ-1:0]   r_my_trn;
  logic                 r_chn_reqep;
  logic                 r_chn_drvn;
  logic                 r_wdog_evt;
  logic                 w_wdog_fire;

  // ---------------- winner selection ----------------
  // Round-robin: rotate a doubled copy of req_ep so bit 0 is (rr_ptr+1),
  // take the lowest set bit, then map the offset back modulo NUM_REQ.
  logic [2*NUM_REQ-1:0] w_req2;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IDX_W:0]       w_start, w_rr_off, w_rr_sum;
  logic [IDX_W-1:0]     w_rr_idx, w_fp_idx, w_win;

  assign w_req2   = {req_ep, req_ep};
  assign w_start  = {1'b0, r_rr_ptr} + {{IDX_W{1'b0}}, 1'b1};
  assign w_rot    = NUM_REQ'(w_req2 >> w_start);
  assign w_rr_sum = w_start + w_rr_off;
  assign w_rr_idx = IDX_W'((w_rr_sum >= NREQ) ? (w_rr_sum - NREQ) : w_rr_sum);

  // lowest set bit of the rotated request vector
  always_comb begin
    w_rr_off = '0;
    for (int k = NUM_REQ-1; k >= 0; k--)
      if (w_rot[k]) w_rr_off = (IDX_W+1)'(k);
  end

  // lowest set request index for fixed-priority mode
  always_comb begin
    w_fp_idx = '0;
    for (int k = NUM_REQ-1; k >= 0; k--)
      if (req_ep[k]) w_fp_idx = IDX_W'(k);
  end

  assign w_win = (ARB_MODE == 1) ? w_fp_idx : w_rr_idx;

  // ---------------- per-lane view of the latched winner ----------------
  logic [NUM_REQ-1:0] w_win_oh;
  logic               w_win_req, w_win_drv;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign w_win_oh[i] = (r_grant_idx == IDX_W'(i));
  end

  // drv_ep bits of non-winners are masked off here
  assign w_win_req = |(req_ep & w_win_oh);
  assign w_win_drv = |(drv_ep & w_win_oh);

  // ---------------- watchdog ----------------
`ifdef EP_ARB_NCH_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] r_wdog;

  // counts cycles spent in GRANT; cleared whenever the FSM is elsewhere
  always_ff @(posedge clk) begin
    if (rst || r_state != S_GRANT) r_wdog <= '0;
    else                           r_wdog <= r_wdog + 1'b1;
  end

  assign w_wdog_fire = (r_state == S_GRANT) && !w_win_drv && w_win_req && chn_trn &&
                       (r_wdog == WDOG_W'(WDOG_CYCLES - 1));
`else
  logic w_unused_wdog;
  assign w_unused_wdog = (WDOG_CYCLES == 0);
  assign w_wdog_fire   = 1'b0;
`endif

  // ---------------- FSM ----------------
  // next-state: GRANT checks drive, then request drop, then upstream revoke
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:    if (|req_ep)  w_nxt = S_REQ_UP;
      S_REQ_UP:  if (chn_trn)  w_nxt = S_GRANT;
      S_GRANT: begin
        if      (w_win_drv)   w_nxt = S_DRIVE;
        else if (!w_win_req)  w_nxt = S_RELEASE;
        else if (!chn_trn)    w_nxt = S_IDLE;
        else if (w_wdog_fire) w_nxt = S_RELEASE;
      end
      S_DRIVE:   if (!w_win_drv) w_nxt = S_RELEASE;
      S_RELEASE: w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  // state and registered outputs; outputs follow the next state so they
  // line up with it (chn_reqep one cycle after req, my_trn after chn_trn)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_my_trn    <= '0;
      r_chn_reqep <= 1'b0;
      r_chn_drvn  <= 1'b0;
      r_wdog_evt  <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      if (r_state == S_IDLE && |req_ep) r_grant_idx <= w_win;
      // a revocation back to IDLE leaves rr_ptr alone so the same index retries
      if (r_state == S_RELEASE)         r_rr_ptr    <= r_grant_idx;
      r_my_trn    <= (w_nxt == S_GRANT || w_nxt == S_DRIVE) ? w_win_oh : '0;
      r_chn_drvn  <= (w_nxt == S_GRANT || w_nxt == S_DRIVE);
      r_chn_reqep <= (w_nxt == S_REQ_UP || w_nxt == S_GRANT || w_nxt == S_DRIVE);
      r_wdog_evt  <= w_wdog_fire;
    end
  end

  assign my_trn    = r_my_trn;
  assign chn_reqep = r_chn_reqep;
  assign chn_drvn  = r_chn_drvn;
  assign grant_idx = r_grant_idx;
  assign busy      = (r_state != S_IDLE);
  assign wdog_evt  = r_wdog_evt;

endmodule

// File: tb/tb_ep_arb_nch.sv
// Directed bench for ep_arb_nch: one round-robin instance and one
// fixed-priority instance sharing clock and reset.
`timescale 1ns/1ps
module tb_ep_arb_nch;

  logic       clk = 1'b0;
  logic       rst;
  // round-robin instance
  logic [3:0] req, drv, my_trn;
  logic       chn, reqep, drvn, busy, wdog;
  logic [3:0] gidx;
  // fixed-priority instance
  logic [3:0] f_req, f_drv, f_my_trn;
  logic       f_chn, f_reqep, f_drvn, f_busy, f_wdog;
  logic [3:0] f_gidx;

  int n_pass = 0;
  int n_tot  = 0;

  always #2 clk = ~clk;

  ep_arb_nch #(.NUM_REQ(4), .ARB_MODE(0), .IDX_W(4), .WDOG_CYCLES(8)) u_rr (
    .clk(clk), .rst(rst), .req_ep(req), .drv_ep(drv), .my_trn(my_trn),
    .chn_trn(chn), .chn_reqep(reqep), .chn_drvn(drvn), .grant_idx(gidx),
    .busy(busy), .wdog_evt(wdog));

  ep_arb_nch #(.NUM_REQ(4), .ARB_MODE(1), .IDX_W(4), .WDOG_CYCLES(8)) u_fp (
    .clk(clk), .rst(rst), .req_ep(f_req), .drv_ep(f_drv), .my_trn(f_my_trn),
    .chn_trn(f_chn), .chn_reqep(f_reqep), .chn_drvn(f_drvn), .grant_idx(f_gidx),
    .busy(f_busy), .wdog_evt(f_wdog));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    int order [5];
    order = '{1, 2, 3, 0, 1};
    rst = 1'b1; req = '0; drv = '0; chn = 1'b0;
    f_req = '0; f_drv = '0; f_chn = 1'b0;
    tick(); tick();
    chk("rst_my_trn", my_trn, 0);
    chk("rst_reqep",  reqep, 0);
    chk("rst_drvn",   drvn, 0);
    chk("rst_gidx",   gidx, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_wdog",   wdog, 0);
    rst = 1'b0;

    // ---- round-robin, all requesting, upstream granted ----
    chn = 1'b1; req = 4'b1111;
    tick();                                   // REQ_UP
    chk("rr_reqep_lat", reqep, 1);
    chk("rr_first_idx", gidx, 1);
    chk("rr_noearly",   my_trn, 0);
    tick();                                   // GRANT
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant", my_trn, 32'd1 << order[i]);
      chk("rr_drvn",  drvn, 1);
      drv = 4'(32'd1 << order[i]);
      for (int d = 0; d < 3; d++) begin
        tick();                               // DRIVE
        chk("rr_drive", my_trn, 32'd1 << order[i]);
      end
      drv = '0;
      tick();                                 // RELEASE
      chk("rr_rel_trn",   my_trn, 0);
      chk("rr_rel_reqep", reqep, 0);
      chk("rr_rel_drvn",  drvn, 0);
      if (i == 4) req = '0;
      tick();                                 // IDLE
      chk("rr_idle_reqep", reqep, 0);
      if (i < 4) begin
        tick();                               // REQ_UP
        chk("rr_next_idx", gidx, order[i+1]);
        chk("rr_up_reqep", reqep, 1);
        chk("rr_up_trn",   my_trn, 0);
        tick();                               // GRANT
      end
    end
    chk("rr_idle_busy", busy, 0);             // rr_ptr now 1

    // ---- upstream withheld ----
    chn = 1'b0; req = 4'b0100;
    tick();                                   // cycle 1
    chk("up_reqep_c1", reqep, 1);
    chk("up_idx",      gidx, 2);
    for (int c = 2; c <= 10; c++) begin
      tick();
      chk("up_wait_trn", my_trn, 0);
    end
    chn = 1'b1;                               // raised in cycle 10
    tick();                                   // cycle 11
    chk("up_grant", my_trn, 4'b0100);

    // ---- revocation in GRANT: same index retried ----
    req = 4'b0101; chn = 1'b0;
    tick();                                   // IDLE
    chk("rev_trn",   my_trn, 0);
    chk("rev_busy",  busy, 0);
    chk("rev_reqep", reqep, 0);
    tick();                                   // REQ_UP
    chk("rev_reselect", gidx, 2);
    chn = 1'b1;
    tick();                                   // GRANT
    chk("rev_regrant", my_trn, 4'b0100);

    // ---- revocation ignored in DRIVE ----
    drv = 4'b0100;
    tick();                                   // DRIVE
    chn = 1'b0;
    tick();
    chk("drv_hold_trn",  my_trn, 4'b0100);
    chk("drv_hold_drvn", drvn, 1);
    tick();
    chk("drv_hold_trn2", my_trn, 4'b0100);
    drv = '0; req = '0;
    tick();                                   // RELEASE
    chk("drv_rel_trn",   my_trn, 0);
    chk("drv_rel_drvn",  drvn, 0);
    chk("drv_rel_reqep", reqep, 0);
    chk("drv_rel_busy",  busy, 1);
    tick();                                   // IDLE, rr_ptr=2
    chk("drv_idle_busy", busy, 0);

    // ---- reset during DRIVE ----
    chn = 1'b1; req = 4'b0001;
    tick();                                   // REQ_UP
    chk("rst_sel_idx", gidx, 0);
    tick();                                   // GRANT
    drv = 4'b0001;
    tick();                                   // DRIVE
    chk("rst_pre_trn", my_trn, 4'b0001);
    rst = 1'b1;
    tick();
    chk("rstd_trn",   my_trn, 0);
    chk("rstd_reqep", reqep, 0);
    chk("rstd_drvn",  drvn, 0);
    chk("rstd_busy",  busy, 0);
    rst = 1'b0; drv = '0; req = '0; chn = 1'b0;
    tick();

    // ---- fixed priority: index 1 always beats 3 ----
    f_chn = 1'b1; f_req = 4'b1010;
    for (int r = 0; r < 3; r++) begin
      tick();                                 // REQ_UP
      chk("fp_idx", f_gidx, 1);
      tick();                                 // GRANT
      chk("fp_grant", f_my_trn, 4'b0010);
      f_drv = 4'b0010;
      tick();                                 // DRIVE
      chk("fp_no3", f_my_trn[3], 0);
      f_drv = '0;
      tick();                                 // RELEASE
      chk("fp_rel", f_my_trn, 0);
      tick();                                 // IDLE
    end
    f_req = '0; f_chn = 1'b0;

`ifdef EP_ARB_NCH_WDOG_EN
    // ---- watchdog: winner never drives ----
    chn = 1'b1; req = 4'b0110;                // rr_ptr=0 after reset
    tick();                                   // REQ_UP
    chk("wd_idx", gidx, 1);
    tick();                                   // GRANT, cycle 0
    chk("wd_grant", my_trn, 4'b0010);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("wd_quiet", wdog, 0);
      chk("wd_hold",  my_trn, 4'b0010);
    end
    tick();                                   // cycle 8: RELEASE
    chk("wd_evt",     wdog, 1);
    chk("wd_rel_trn", my_trn, 0);
    tick();                                   // IDLE
    chk("wd_evt_1cyc", wdog, 0);
    tick();                                   // REQ_UP
    chk("wd_next_idx", gidx, 2);
    req = '0; chn = 1'b0;
`else
    // ---- without the watchdog GRANT waits indefinitely ----
    chn = 1'b1; req = 4'b0010;
    tick(); tick();                           // GRANT
    for (int k = 0; k < 20; k++) tick();
    chk("nowd_hold", my_trn, 4'b0010);
    chk("nowd_evt",  wdog, 0);
    req = '0;
    tick();                                   // RELEASE
    chk("nowd_rel", my_trn, 0);
    chn = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
